// File: rtl/kbd_rx_fifo_if.sv
// CPU/keyboard-side signal bundle for kbd_rx_fifo; master = keyboard decoder plus CPU bus, slave = the FIFO.
interface kbd_rx_fifo_if #(parameter int AW = 4);
  logic [7:0]  key_ascii;
  logic        key_pressed;
  logic        key_released;
  logic        rd_sel;
  logic        rd_reg;
  logic [63:0] rd_data;
  logic [3:0]  interrupt_vector;
  logic        interrupt_done;
  logic [AW:0] fifo_count;

  modport master (
    output key_ascii, key_pressed, key_released, rd_sel, rd_reg, interrupt_done,
    input  rd_data, interrupt_vector, fifo_count
  );

  modport slave (
    input  key_ascii, key_pressed, key_released, rd_sel, rd_reg, interrupt_done,
    output rd_data, interrupt_vector, fifo_count
  );
endinterface

// File: rtl/kbd_rx_fifo.sv
// Key-event FIFO between ps2_decoder and the CPU bus with IRQ handshake; KBD_BREAK_EN also queues key releases.
// Push/pop act on the posedge that sees the strobe edge, rd_data is combinational; a push into a full FIFO is dropped and flagged.
module kbd_rx_fifo #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [3:0] IRQ_VEC = 4'd1
) (
  input  logic           CLOCK_50,
  input  logic           KEY0,
  kbd_rx_fifo_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} irq_state_e;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          press_q, press_d;
  logic          rd_sel_q, rd_sel_d;
  logic          armed_q, armed_d;
  irq_state_e    state_q, state_d;
  logic [3:0]    vec_q, vec_d;

  logic          full, empty, ascii_nz;
  logic          press_edge, rel_edge, rd_edge;
  logic          wr_req, do_push, do_pop, ovf_set, ovf_clr;
  logic [8:0]    wr_entry;
  logic [63:0]   rd_data;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign ascii_nz = (bus.key_ascii != 8'd0);

  // armed_q blocks a push from a key already held high when reset is released
  assign press_edge = armed_q && bus.key_pressed && !press_q && ascii_nz;
  assign rd_edge    = bus.rd_sel && !rd_sel_q;

`ifdef KBD_BREAK_EN
  logic rel_q, rel_d;
  assign rel_edge = armed_q && bus.key_released && !rel_q && ascii_nz;
  always_comb begin
    rel_d = bus.key_released;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) rel_q <= 1'b0;
    else       rel_q <= rel_d;
  end
`else
  assign rel_edge = 1'b0;
`endif

  always_comb begin
    press_d  = bus.key_pressed;
    rd_sel_d = bus.rd_sel;
    armed_d  = 1'b1;

    do_pop   = rd_edge && !bus.rd_reg && !empty;
    ovf_clr  = rd_edge && bus.rd_reg;

    // A coincident release loses to the press and is reported as an overflow
    wr_req   = press_edge || rel_edge;
    wr_entry = press_edge ? {1'b0, bus.key_ascii} : {1'b1, bus.key_ascii};
    do_push  = wr_req && (!full || do_pop);
    ovf_set  = (wr_req && full && !do_pop) || (press_edge && rel_edge);

    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);

    overflow_d = overflow_q;
    if (ovf_set)      overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_comb begin
    rd_data = 64'd0;
    if (bus.rd_reg)  rd_data = {54'd0, overflow_q, full, 8'(count_q)};
    else if (!empty) rd_data = {55'd0, mem_q[rd_ptr_q]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty && bus.interrupt_done) state_d = REQ;
      REQ:     if (!bus.interrupt_done)          state_d = SERV;
      SERV:    if (bus.interrupt_done)           state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
    vec_d = (state_d == REQ) ? IRQ_VEC : 4'd0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      press_q    <= 1'b0;
      rd_sel_q   <= 1'b0;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      vec_q      <= 4'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      press_q    <= press_d;
      rd_sel_q   <= rd_sel_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      vec_q      <= vec_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it
  always_ff @(posedge CLOCK_50) begin
    if (KEY0 && do_push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign bus.rd_data          = rd_data;
  assign bus.interrupt_vector = vec_q;
  assign bus.fifo_count       = count_q;

endmodule

// File: tb/tb_kbd_rx_fifo.sv
// Directed bench for kbd_rx_fifo: push/pop strobes, overflow/status, IRQ handshake, break codes and reset.
module tb_kbd_rx_fifo;
  logic CLOCK_50;
  logic KEY0;
  int   total;
  int   bad;

  kbd_rx_fifo_if #(.AW(4)) bus ();

  kbd_rx_fifo #(.DEPTH(16), .AW(4), .IRQ_VEC(4'd1)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] a);
    bus.key_ascii   = a;
    bus.key_pressed = 1'b1;
    tick();
    bus.key_pressed = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] exp);
    bus.rd_reg = 1'b0;
    #1;
    chk(tag, bus.rd_data, exp);
    bus.rd_sel = 1'b1;
    tick();
    bus.rd_sel = 1'b0;
    tick();
  endtask

  task automatic status_chk(input string tag, input logic [63:0] exp);
    bus.rd_reg = 1'b1;
    #1;
    chk(tag, bus.rd_data, exp);
    bus.rd_reg = 1'b0;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    KEY0  = 1'b0;
    bus.key_ascii      = 8'd0;
    bus.key_pressed    = 1'b0;
    bus.key_released   = 1'b0;
    bus.rd_sel         = 1'b0;
    bus.rd_reg         = 1'b0;
    bus.interrupt_done = 1'b1;
    tick(2);
    chk("reset_count", 64'(bus.fifo_count), 64'd0);
    chk("reset_vec", 64'(bus.interrupt_vector), 64'd0);
    chk("reset_rd_data", bus.rd_data, 64'd0);
    KEY0 = 1'b1;
    tick(2);

    // single strobe held for 1000 cycles pops exactly one entry
    bus.key_ascii   = 8'h41;
    bus.key_pressed = 1'b1;
    tick();
    chk("push_a_count", 64'(bus.fifo_count), 64'd1);
    bus.key_pressed = 1'b0;
    tick();
    chk("push_a_vec", 64'(bus.interrupt_vector), 64'd1);
    press(8'h42);
    chk("push_b_count", 64'(bus.fifo_count), 64'd2);
    bus.rd_reg = 1'b0;
    #1;
    chk("head_a", bus.rd_data, 64'h41);
    bus.rd_sel = 1'b1;
    tick(1000);
    chk("held_count", 64'(bus.fifo_count), 64'd1);
    chk("held_head_b", bus.rd_data, 64'h42);
    bus.rd_sel = 1'b0;
    tick();
    pop_chk("pop_b", 64'h42);
    chk("drained_count", 64'(bus.fifo_count), 64'd0);

    // empty read is harmless
    pop_chk("empty_read", 64'd0);
    chk("empty_count", 64'(bus.fifo_count), 64'd0);
    chk("req_held_when_empty", 64'(bus.interrupt_vector), 64'd1);

    // 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) begin
      logic [7:0] a;
      a = 8'h30 + 8'(i);
      press(a);
    end
    chk("full_count", 64'(bus.fifo_count), 64'd16);
    status_chk("status_ovf", 64'h310);
    bus.rd_reg = 1'b1;
    bus.rd_sel = 1'b1;
    tick();
    bus.rd_sel = 1'b0;
    tick();
    status_chk("status_cleared", 64'h110);

    // full FIFO: push and pop on the same posedge
    bus.rd_reg      = 1'b0;
    bus.key_ascii   = 8'h60;
    #1;
    chk("full_head", bus.rd_data, 64'h30);
    bus.key_pressed = 1'b1;
    bus.rd_sel      = 1'b1;
    tick();
    chk("full_pushpop_count", 64'(bus.fifo_count), 64'd16);
    bus.key_pressed = 1'b0;
    bus.rd_sel      = 1'b0;
    tick();
    status_chk("full_pushpop_status", 64'h110);
    for (int i = 1; i < 16; i++) begin
      pop_chk($sformatf("order_%0d", i), 64'h30 + 64'(i));
    end
    pop_chk("tail_new", 64'h60);
    chk("order_end_count", 64'(bus.fifo_count), 64'd0);

    // IRQ handshake with two entries pending
    press(8'h61);
    press(8'h62);
    bus.interrupt_done = 1'b0;
    tick();
    chk("serv_vec_drop", 64'(bus.interrupt_vector), 64'd0);
    tick(3);
    chk("serv_vec_low", 64'(bus.interrupt_vector), 64'd0);
    bus.interrupt_done = 1'b1;
    tick();
    chk("idle_vec_low", 64'(bus.interrupt_vector), 64'd0);
    tick();
    chk("rereq_vec", 64'(bus.interrupt_vector), 64'd1);
    pop_chk("irq_pop_1", 64'h61);
    pop_chk("irq_pop_2", 64'h62);

    // press then release of 'z'
    bus.key_ascii   = 8'h7A;
    bus.key_pressed = 1'b1;
    tick();
    bus.key_pressed  = 1'b0;
    bus.key_released = 1'b1;
    tick();
    bus.key_released = 1'b0;
    tick();
`ifdef KBD_BREAK_EN
    chk("brk_count", 64'(bus.fifo_count), 64'd2);
    pop_chk("brk_make", 64'h07A);
    pop_chk("brk_break", 64'h17A);
`else
    chk("brk_count", 64'(bus.fifo_count), 64'd1);
    pop_chk("brk_make", 64'h07A);
`endif
    chk("brk_end_count", 64'(bus.fifo_count), 64'd0);

    // reset mid-stream, with a key held across reset release
    for (int i = 0; i < 5; i++) press(8'h50 + 8'(i));
    chk("pre_reset_count", 64'(bus.fifo_count), 64'd5);
    bus.key_ascii   = 8'h55;
    bus.key_pressed = 1'b1;
    KEY0 = 1'b0;
    tick();
    chk("mid_reset_count", 64'(bus.fifo_count), 64'd0);
    chk("mid_reset_vec", 64'(bus.interrupt_vector), 64'd0);
    KEY0 = 1'b1;
    tick();
    chk("no_push_after_reset", 64'(bus.fifo_count), 64'd0);
    bus.key_pressed = 1'b0;
    tick();
    press(8'h44);
    pop_chk("post_reset_pop", 64'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
